mblock_stage_sequencer: RTL and testbench

- Parametrised, clocked successor to the combinational memory-block address mux.
- Steps one instruction through its memory stages: fetch at program_counter, then up to NUM_SRC-1 operand stages.
- Each stage drives a registered address and mblock selector (RAM/BROM/IO/CONST) and runs a req/ack handshake with the memory-block arbiter.
- Per-stage selector, enable and write controls come from the decoded instruction_op, sampled at the fetch acknowledge.

---
 rtl/mblock_stage_sequencer_if.sv | 22 ++
 rtl/mblock_stage_sequencer.sv | 175 +++++++++++++++++
 tb/tb_mblock_stage_sequencer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mblock_stage_sequencer_if.sv
// Memory-block bus between the stage sequencer and the memory-block arbiter.
// The sequencer drives address/selector/req/write; the arbiter answers with ack.
interface mblock_stage_sequencer_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int SEL_WIDTH  = 2
);
   logic [ADDR_WIDTH-1:0] mblock_address;
   logic [SEL_WIDTH-1:0]  mblock_selector;
   logic                  mblock_req;
   logic                  mblock_write;
   logic                  mblock_ack;

   modport master (
      output mblock_address, mblock_selector, mblock_req, mblock_write,
      input  mblock_ack
   );

   modport slave (
      input  mblock_address, mblock_selector, mblock_req, mblock_write,
      output mblock_ack
   );
endinterface

// File: rtl/mblock_stage_sequencer.sv
// Memory-stage sequencer: walks one instruction through a fetch stage and up
// to NUM_SRC-1 operand stages, presenting a registered address/selector per
// stage and handshaking each one with the memory-block arbiter.
module mblock_stage_sequencer #(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_SRC    = 4,
   parameter int SEL_WIDTH  = 2
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            start,
   input  logic                            execute_from_brom,
   input  logic [NUM_SRC*ADDR_WIDTH-1:0]   address_src,
   input  logic [(NUM_SRC-1)*SEL_WIDTH-1:0] op_sel,
   input  logic [NUM_SRC-2:0]              op_stage_en,
   input  logic [NUM_SRC-2:0]              op_is_write,
   mblock_stage_sequencer_if.master        mb,
   output logic [NUM_SRC-1:0]              is_stage,
   output logic                            busy,
   output logic                            done
);
   localparam int IDX_W = (NUM_SRC > 2) ? $clog2(NUM_SRC) : 1;
   localparam logic [SEL_WIDTH-1:0] SEL_CONST = SEL_WIDTH'(3);

   typedef enum logic [1:0] {S_IDLE, S_STAGE, S_DONE} state_t;

   state_t                           state_q, state_d;
   logic [IDX_W-1:0]                 stg_q, stg_d;
   logic [ADDR_WIDTH-1:0]            addr_q, addr_d;
   logic [SEL_WIDTH-1:0]             sel_q, sel_d;
   logic                             req_q, req_d;
   logic                             wr_q, wr_d;
   logic [NUM_SRC-1:0]               is_q, is_d;
   logic                             busy_q, busy_d;
   logic                             done_q, done_d;
   logic [(NUM_SRC-1)*SEL_WIDTH-1:0] op_sel_q, op_sel_d;
   logic [NUM_SRC-2:0]               op_en_q, op_en_d;
   logic [NUM_SRC-2:0]               op_wr_q, op_wr_d;

   // Codes above CONST only exist for wide selectors; they fall back to RAM.
   function automatic logic [SEL_WIDTH-1:0] norm_sel(input logic [SEL_WIDTH-1:0] s);
      norm_sel = (32'(s) > 32'd3) ? '0 : s;
   endfunction

   // Successor-stage search; the fetch stage looks at the live op fields
   // because they are only latched on the very edge that leaves it.
   logic [(NUM_SRC-1)*SEL_WIDTH-1:0] sels;
   logic [NUM_SRC-2:0]               mask, wrs;
   logic                             nxt_found, nxt_wr, stage_done;
   logic [IDX_W-1:0]                 nxt_idx;
   logic [SEL_WIDTH-1:0]             nxt_sel;
   logic [ADDR_WIDTH-1:0]            nxt_addr;

   // Next-state and registered-output logic.
   always_comb begin
      state_d  = state_q;
      stg_d    = stg_q;
      addr_d   = addr_q;
      sel_d    = sel_q;
      req_d    = req_q;
      wr_d     = wr_q;
      is_d     = is_q;
      busy_d   = busy_q;
      done_d   = done_q;
      op_sel_d = op_sel_q;
      op_en_d  = op_en_q;
      op_wr_d  = op_wr_q;

      mask = (stg_q == '0) ? op_stage_en : op_en_q;
      sels = (stg_q == '0) ? op_sel      : op_sel_q;
      wrs  = (stg_q == '0) ? op_is_write : op_wr_q;

      nxt_found = 1'b0;
      nxt_idx   = '0;
      nxt_sel   = '0;
      nxt_wr    = 1'b0;
      nxt_addr  = '0;
      // Descending scan so the lowest enabled stage wins.
      for (int j = NUM_SRC - 1; j >= 1; j--) begin
         if (j > int'(stg_q) && mask[j-1]) begin
            nxt_found = 1'b1;
            nxt_idx   = IDX_W'(j);
            nxt_sel   = norm_sel(sels[(j-1)*SEL_WIDTH +: SEL_WIDTH]);
            nxt_wr    = wrs[j-1];
            nxt_addr  = address_src[j*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end

      // A CONST stage has no request, so it completes on its own.
      stage_done = req_q ? mb.mblock_ack : 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_STAGE;
               stg_d   = '0;
               addr_d  = address_src[ADDR_WIDTH-1:0];
               sel_d   = {{(SEL_WIDTH-1){1'b0}}, execute_from_brom};
               req_d   = 1'b1;
               wr_d    = 1'b0;
               is_d    = NUM_SRC'(1);
               busy_d  = 1'b1;
            end
         end
         S_STAGE: begin
            if (stage_done) begin
               if (stg_q == '0) begin
                  op_sel_d = op_sel;
                  op_en_d  = op_stage_en;
                  op_wr_d  = op_is_write;
               end
               if (nxt_found) begin
                  stg_d  = nxt_idx;
                  addr_d = nxt_addr;
                  sel_d  = nxt_sel;
                  req_d  = (nxt_sel != SEL_CONST);
                  wr_d   = nxt_wr & (nxt_sel != SEL_CONST);
                  is_d   = NUM_SRC'(1) << nxt_idx;
               end else begin
                  state_d = S_DONE;
                  req_d   = 1'b0;
                  wr_d    = 1'b0;
                  is_d    = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            done_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register; reset abandons any in-flight transaction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         stg_q    <= '0;
         addr_q   <= '0;
         sel_q    <= '0;
         req_q    <= 1'b0;
         wr_q     <= 1'b0;
         is_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         op_sel_q <= '0;
         op_en_q  <= '0;
         op_wr_q  <= '0;
      end else begin
         state_q  <= state_d;
         stg_q    <= stg_d;
         addr_q   <= addr_d;
         sel_q    <= sel_d;
         req_q    <= req_d;
         wr_q     <= wr_d;
         is_q     <= is_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         op_sel_q <= op_sel_d;
         op_en_q  <= op_en_d;
         op_wr_q  <= op_wr_d;
      end
   end

   assign mb.mblock_address  = addr_q;
   assign mb.mblock_selector = sel_q;
   assign mb.mblock_req      = req_q;
   assign mb.mblock_write    = wr_q;
   assign is_stage           = is_q;
   assign busy               = busy_q;
   assign done               = done_q;
endmodule

// File: tb/tb_mblock_stage_sequencer.sv
// Bench for the memory-stage sequencer: a driver issues instructions and pushes
// the expected stage list into a scoreboard; a monitor pops and compares.
module tb_mblock_stage_sequencer;
   localparam int AW = 32;
   localparam int NS = 4;
   localparam int SW = 2;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic                  start = 1'b0;
   logic                  execute_from_brom = 1'b0;
   logic [NS*AW-1:0]      address_src = '0;
   logic [(NS-1)*SW-1:0]  op_sel = '0;
   logic [NS-2:0]         op_stage_en = '0;
   logic [NS-2:0]         op_is_write = '0;
   logic                  ack = 1'b0;
   logic [NS-1:0]         is_stage;
   logic                  busy, done;

   mblock_stage_sequencer_if #(.ADDR_WIDTH(AW), .SEL_WIDTH(SW)) mbif ();
   assign mbif.mblock_ack = ack;

   mblock_stage_sequencer #(.ADDR_WIDTH(AW), .NUM_SRC(NS), .SEL_WIDTH(SW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .execute_from_brom(execute_from_brom), .address_src(address_src),
      .op_sel(op_sel), .op_stage_en(op_stage_en), .op_is_write(op_is_write),
      .mb(mbif.master), .is_stage(is_stage), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          is_done;
      logic [NS-1:0] stg;
      logic [AW-1:0] addr;
      logic [SW-1:0] sel;
      logic          wr;
      logic          req;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
      end
   endtask

   function automatic bit outs_zero();
      return is_stage == '0 && !busy && !done && !mbif.mblock_req && !mbif.mblock_write &&
             mbif.mblock_address == '0 && mbif.mblock_selector == '0;
   endfunction

   // Monitor: compares every stage/done cycle against the scoreboard head.
   bit   exp_next = 0, done_prev = 0;
   exp_t e;
   initial forever begin
      @(negedge clk); #1;
      if (!reset_n) begin
         exp_next  = 0;
         done_prev = 0;
      end else begin
         if (done_prev) chk("done_1cyc", !done && !busy && is_stage == '0, {done, busy, is_stage}, 0);
         done_prev = done;
         if (exp_next) begin
            exp_next = 0;
            if (q.size() > 0) begin
               if (q[0].is_done) chk("done_lat", done, done, 1);
               else              chk("no_bubble", is_stage == q[0].stg, is_stage, q[0].stg);
            end
         end
         if (done) begin
            if (q.size() == 0) chk("done_unexp", 0, done, 0);
            else begin
               e = q.pop_front();
               chk("done_evt", e.is_done, e.is_done, 1);
               chk("done_outs", !busy && !mbif.mblock_req && !mbif.mblock_write && is_stage == '0,
                   {busy, mbif.mblock_req, mbif.mblock_write, is_stage}, 0);
            end
         end else if (is_stage != '0) begin
            if (q.size() == 0) chk("stage_unexp", 0, is_stage, 0);
            else begin
               e = q[0];
               chk("stage", !e.is_done && is_stage == e.stg, is_stage, e.stg);
               chk("addr", mbif.mblock_address == e.addr, mbif.mblock_address, e.addr);
               chk("sel", mbif.mblock_selector == e.sel, mbif.mblock_selector, e.sel);
               chk("req", mbif.mblock_req == e.req, mbif.mblock_req, e.req);
               chk("write", mbif.mblock_write == e.wr, mbif.mblock_write, e.wr);
               chk("busy", busy, busy, 1);
               if (!mbif.mblock_req || ack) begin
                  void'(q.pop_front());
                  exp_next = 1;
               end
            end
         end
      end
   end

   // One instruction. ack_wait>=0: ack after that many waiting cycles; else
   // random ack with probability pct. rst_stage>=0: reset while in that stage.
   task automatic run_instr(input logic brom, input logic [NS*AW-1:0] srcv,
                            input logic [(NS-1)*SW-1:0] selv, input logic [NS-2:0] en,
                            input logic [NS-2:0] wr, input int ack_wait, input int pct,
                            input int rst_stage, input bit corrupt);
      exp_t          r;
      int            lat, cyc, wcnt, n;
      logic [NS-1:0] last;
      logic [SW-1:0] s;
      bit            seen;
      n = 0;
      while ((busy || done || is_stage != '0) && n < 50) begin
         @(negedge clk); start = 0; ack = 0; n++;
      end
      @(negedge clk);
      address_src = srcv; execute_from_brom = brom;
      op_sel = selv; op_stage_en = en; op_is_write = wr;
      ack = 0; start = 1;
      // Reference: the stage list implied by the instruction fields.
      r = '{1'b0, NS'(1), srcv[AW-1:0], {1'b0, brom}, 1'b0, 1'b1};
      q.push_back(r);
      lat = 1 + ack_wait + 1;
      for (int j = 1; j < NS; j++) begin
         if (en[j-1]) begin
            s = selv[(j-1)*SW +: SW];
            r = '{1'b0, NS'(1) << j, srcv[j*AW +: AW], s, wr[j-1] && s != 2'd3, s != 2'd3};
            q.push_back(r);
            lat += (s == 2'd3) ? 1 : ack_wait + 1;
         end
      end
      r = '0; r.is_done = 1'b1;
      q.push_back(r);

      cyc = 0; wcnt = 0; last = '0; seen = 0;
      while (!seen && cyc < 300) begin
         @(negedge clk); cyc++;
         if (cyc == 1) chk("start_lat", is_stage == NS'(1) && busy, {busy, is_stage}, 5'h11);
         start = (busy || done) ? 1'($urandom) : 1'b0;
         if (done) begin
            seen = 1;
            if (ack_wait >= 0) chk("latency", cyc == lat, cyc, lat);
         end
         if (rst_stage >= 0 && is_stage[rst_stage] && mbif.mblock_req) begin
            ack = 0; start = 0;
            #2 reset_n = 0;
            #1 chk("async_rst", outs_zero(), {busy, done, mbif.mblock_req, is_stage}, 0);
            q.delete();
            @(negedge clk); @(negedge clk);
            reset_n = 1;
            @(negedge clk); ack = 1;
            @(negedge clk); ack = 0;
            chk("ack_after_rst", outs_zero(), {busy, mbif.mblock_req, is_stage}, 0);
            return;
         end
         if (is_stage != last) begin wcnt = 0; last = is_stage; end
         if (ack_wait >= 0) ack = mbif.mblock_req && wcnt >= ack_wait;
         else               ack = ($urandom_range(99) < pct);
         wcnt++;
         if (corrupt) begin
            for (int k = 0; k < NS; k++)
               if (is_stage[k] && $urandom_range(1) == 1) address_src[k*AW +: AW] = $urandom;
            if (is_stage != '0 && !is_stage[0]) begin
               op_sel = 6'($urandom); op_stage_en = 3'($urandom); op_is_write = 3'($urandom);
            end
         end
      end
      if (!seen) chk("timeout", 0, cyc, lat);
      @(negedge clk); start = 0; ack = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [NS*AW-1:0] sv;
   initial begin
      repeat (2) @(negedge clk);
      chk("reset_state", outs_zero(), {busy, done, mbif.mblock_req, is_stage}, 0);
      reset_n = 1;
      @(negedge clk);
      chk("idle_after_rst", outs_zero(), {busy, done, is_stage}, 0);

      // BROM fetch, ack after 3 waiting cycles, no operands.
      sv = '0; sv[AW-1:0] = 32'h0000_0100;
      run_instr(1'b1, sv, '0, 3'b000, 3'b000, 3, 0, -1, 0);
      // Full sequence, RAM/IO/RAM, ack every cycle.
      sv = {32'h30, 32'h20, 32'h10, 32'h200};
      run_instr(1'b0, sv, {2'd0, 2'd2, 2'd0}, 3'b111, 3'b000, 0, 0, -1, 0);
      // Sparse mask: straight from fetch to stage 3.
      sv = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'h40};
      run_instr(1'b0, sv, {2'd1, 2'd0, 2'd2}, 3'b100, 3'b100, 1, 0, -1, 0);
      // CONST stage 2 alone.
      sv = {32'h3, 32'hC057, 32'h1, 32'h50};
      run_instr(1'b0, sv, {2'd0, 2'd3, 2'd0}, 3'b010, 3'b010, 0, 0, -1, 0);
      // Write on stage 1 only, 5-cycle waits, sources and op fields disturbed.
      sv = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'h60};
      run_instr(1'b0, sv, {2'd0, 2'd0, 2'd0}, 3'b111, 3'b001, 5, 0, -1, 1);
      // Minimal latency.
      sv = {32'h0, 32'h0, 32'h0, 32'h70};
      run_instr(1'b0, sv, '0, 3'b000, 3'b000, 0, 0, -1, 0);
      // Reset mid stage 1, then a fresh instruction from fetch.
      sv = {32'h33, 32'h22, 32'h11, 32'h80};
      run_instr(1'b0, sv, '0, 3'b111, 3'b111, 2, 0, 1, 0);
      run_instr(1'b1, sv, {2'd2, 2'd1, 2'd0}, 3'b011, 3'b011, 1, 0, -1, 0);

      // Randomized instructions.
      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < NS; k++) sv[k*AW +: AW] = $urandom;
         run_instr(1'($urandom), sv, 6'($urandom), 3'($urandom), 3'($urandom),
                   (i % 3 == 0) ? $urandom_range(3) : -1, $urandom_range(100, 20), -1, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
